// File: rtl/hazard_controller_if.sv
// Decode-stage hazard controller bus: ID instruction fields in,
// stall/bubble/flush strobes and forwarding selects out.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             freeze;
    logic             id_valid;
    logic [5:0]       id_op_code;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_ws;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output freeze, id_valid, id_op_code,
        output id_rs1, id_rs2, id_ws,
        input  stall, bubble, flush,
        input  fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  freeze, id_valid, id_op_code,
        input  id_rs1, id_rs2, id_ws,
        output stall, bubble, flush,
        output fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Load-use stall, jump flush and registered ALU forwarding selects
// for the ID -> EX -> MEM -> WB pipeline.
module hazard_controller #(
    parameter int         CNT_W   = 16,
    parameter logic [5:0] LOAD_OP = 6'b100011
) (
    input logic clk,
    input logic reset,
    hazard_controller_if.slave bus
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       load;
    } ex_slot_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } mem_slot_t;

    ex_slot_t         ex_q;
    mem_slot_t        mem_q;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] cnt_q;

    logic       rd_rs1;
    logic       rd_rs2;
    logic       wr_en;
    logic       is_r;
    logic       is_jump;
    logic       is_load;
    logic       use1;
    logic       use2;
    logic [4:0] wr_reg;
    logic       writes;
    logic       hazard;
    logic       stall_c;
    logic       bubble_c;
    logic       flush_c;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;

    always_comb begin
        rd_rs1  = 1'b1;
        rd_rs2  = 1'b0;
        wr_en   = 1'b1;
        is_r    = 1'b0;
        is_jump = 1'b0;
        is_load = 1'b0;
        unique case (1'b1)
            bus.id_op_code == 6'b000000,
            bus.id_op_code == 6'b010000: begin
                rd_rs2 = 1'b1;
                is_r   = 1'b1;
            end
            bus.id_op_code == 6'b000010,
            bus.id_op_code == 6'b010011: begin
                rd_rs1  = 1'b0;
                wr_en   = 1'b0;
                is_jump = 1'b1;
            end
            bus.id_op_code == 6'b000100,
            bus.id_op_code == 6'b000101,
            bus.id_op_code == 6'b101011: begin
                rd_rs2 = 1'b1;
                wr_en  = 1'b0;
            end
            bus.id_op_code == LOAD_OP: begin
                is_load = 1'b1;
            end
            default: begin
                rd_rs1 = 1'b1;
            end
        endcase
    end

    // r0 is hardwired, so it never participates in a dependency
    always_comb begin
        use1   = rd_rs1 && (bus.id_rs1 != 5'd0);
        use2   = rd_rs2 && (bus.id_rs2 != 5'd0);
        wr_reg = is_r ? bus.id_ws : bus.id_rs2;
        writes = wr_en && (wr_reg != 5'd0);
        hazard = bus.id_valid && ex_q.v && ex_q.load &&
                 ((use1 && bus.id_rs1 == ex_q.rd) ||
                  (use2 && bus.id_rs2 == ex_q.rd));
        stall_c  = bus.freeze || hazard;
        bubble_c = !bus.freeze && hazard;
        flush_c  = !bus.freeze && bus.id_valid && is_jump && !hazard;
    end

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (bus.id_valid && !bubble_c) begin
            if (use1 && ex_q.v && !ex_q.load && bus.id_rs1 == ex_q.rd)
                fwd_a_d = 2'b01;
            else if (use1 && mem_q.v && bus.id_rs1 == mem_q.rd)
                fwd_a_d = 2'b10;
            if (use2 && ex_q.v && !ex_q.load && bus.id_rs2 == ex_q.rd)
                fwd_b_d = 2'b01;
            else if (use2 && mem_q.v && bus.id_rs2 == mem_q.rd)
                fwd_b_d = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            cnt_q   <= '0;
        end else if (!bus.freeze) begin
            mem_q.v  <= ex_q.v;
            mem_q.rd <= ex_q.rd;
            ex_q.v    <= bus.id_valid && writes && !bubble_c;
            ex_q.rd   <= wr_reg;
            ex_q.load <= is_load;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (bubble_c && !(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.bubble      = bubble_c;
    assign bus.flush       = flush_c;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use, forwarding, jump flush,
// freeze, r0, counter saturation and async reset.
module tb_hazard_controller;

    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_controller_if #(.CNT_W(CNT_W)) hif ();

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [5:0] op,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] ws);
        hif.id_valid   = v;
        hif.id_op_code = op;
        hif.id_rs1     = rs1;
        hif.id_rs2     = rs2;
        hif.id_ws      = ws;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic s,
                            input logic b, input logic f);
        chk({tag, ".stall"}, {15'd0, hif.stall}, {15'd0, s});
        chk({tag, ".bubble"}, {15'd0, hif.bubble}, {15'd0, b});
        chk({tag, ".flush"}, {15'd0, hif.flush}, {15'd0, f});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a,
                           input logic [1:0] b);
        chk({tag, ".fwd_a"}, {14'd0, hif.fwd_a}, {14'd0, a});
        chk({tag, ".fwd_b"}, {14'd0, hif.fwd_b}, {14'd0, b});
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] c);
        chk({tag, ".count"}, {12'd0, hif.stall_count}, {12'd0, c});
    endtask

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b010000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        hif.freeze = 1'b0;
        set_id(1'b0, OP_ADDI, 5'd0, 5'd0, 5'd0);
        #10;
        chk_fwd("rst", 2'b00, 2'b00);
        chk_cnt("rst", 4'd0);
        chk_comb("rst", 1'b0, 1'b0, 1'b0);
        #10;
        reset = 1'b0;
        tick();

        // add r3,r1,r2 then sub r4,r3,r5
        set_id(1'b1, OP_ADD, 5'd1, 5'd2, 5'd3);
        chk_comb("add", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("add_ex", 2'b00, 2'b00);
        set_id(1'b1, OP_SUB, 5'd3, 5'd5, 5'd4);
        chk_comb("sub", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("sub_ex", 2'b01, 2'b00);

        // lw r5 then add r6,r5,r5
        set_id(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
        chk_comb("lw5", 1'b0, 1'b0, 1'b0);
        tick();
        set_id(1'b1, OP_ADD, 5'd5, 5'd5, 5'd6);
        chk_comb("lu", 1'b1, 1'b1, 1'b0);
        tick();
        chk_cnt("lu", 4'd1);
        chk_fwd("lu_bub", 2'b00, 2'b00);
        chk_comb("lu_re", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("lu_ex", 2'b10, 2'b10);

        // jump flushes for one cycle only
        set_id(1'b1, OP_J, 5'd6, 5'd6, 5'd0);
        chk_comb("jmp", 1'b0, 1'b0, 1'b1);
        tick();
        set_id(1'b1, OP_ADDI, 5'd1, 5'd7, 5'd0);
        chk_comb("jmp_nxt", 1'b0, 1'b0, 1'b0);
        tick();

        // lw r8 uses r7 from addi in EX, then add r9,r8,r0 under freeze
        set_id(1'b1, OP_LW, 5'd7, 5'd8, 5'd0);
        tick();
        chk_fwd("lw8_ex", 2'b01, 2'b00);
        set_id(1'b1, OP_ADD, 5'd8, 5'd0, 5'd9);
        chk_comb("fz_pre", 1'b1, 1'b1, 1'b0);
        hif.freeze = 1'b1;
        #1;
        chk_comb("fz", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_comb("fz_hold", 1'b1, 1'b0, 1'b0);
            chk_fwd("fz_hold", 2'b01, 2'b00);
            chk_cnt("fz_hold", 4'd1);
        end
        hif.freeze = 1'b0;
        #1;
        chk_comb("fz_rel", 1'b1, 1'b1, 1'b0);
        tick();
        chk_cnt("fz_rel", 4'd2);
        chk_fwd("fz_bub", 2'b00, 2'b00);
        chk_comb("fz_re", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("fz_ex", 2'b10, 2'b00);

        // r0 producers never create hazards or forwarding
        set_id(1'b1, OP_ADDI, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd10);
        chk_comb("r0_alu", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("r0_alu", 2'b00, 2'b00);
        set_id(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, OP_ADD, 5'd0, 5'd0, 5'd11);
        chk_comb("r0_lw", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("r0_lw", 2'b00, 2'b00);
        chk_cnt("r0", 4'd2);

        // repeated load-use hazards saturate the counter
        for (int i = 0; i < 15; i++) begin
            set_id(1'b1, OP_LW, 5'd1, 5'd12, 5'd0);
            tick();
            set_id(1'b1, OP_ADD, 5'd12, 5'd12, 5'd13);
            tick();
            tick();
            if (i == 11) chk_cnt("sat14", 4'd14);
            if (i == 12) chk_cnt("sat15", 4'd15);
        end
        chk_cnt("sat_hold", 4'd15);

        // async reset in the middle of a load-use stall
        set_id(1'b1, OP_LW, 5'd13, 5'd14, 5'd0);
        tick();
        chk_fwd("lw14_ex", 2'b01, 2'b00);
        set_id(1'b1, OP_ADD, 5'd14, 5'd14, 5'd15);
        chk_comb("ar_pre", 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk_fwd("ar", 2'b00, 2'b00);
        chk_cnt("ar", 4'd0);
        chk_comb("ar", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk_comb("ar_rel", 1'b0, 1'b0, 1'b0);
        tick();
        chk_fwd("ar_ex", 2'b00, 2'b00);
        chk_cnt("ar_ex", 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Decode-stage hazard and forwarding controller for the 4-stage pipeline (ID → EX → MEM → WB). It classifies the instruction fields delivered by the decoder and tracks the destination registers of the two instructions ahead of ID (in EX and MEM). From that state it produces the pipeline stall and bubble strobes, the jump flush strobe, and registered operand-forwarding selects for the ALU inputs. It owns no datapath; the IF/ID and ID/EX registers and the ALU input muxes obey its outputs.

## Interface
- CNT_W, 16, width of the saturating load-use stall counter
- LOAD_OP, 6'b100011, opcode treated as a load (result available only after MEM)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- freeze  in  1  memory wait; holds the entire pipeline
- id_valid  in  1  ID stage holds a real instruction
- id_op_code  in  6  opcode of ID instruction
- id_rs1  in  5  source register 1 field
- id_rs2  in  5  source register 2 / I-type destination field
- id_ws  in  5  R-type destination field
- stall  out  1  hold PC and IF/ID this cycle (comb)
- bubble  out  1  load NOP into ID/EX this cycle (comb)
- flush  out  1  squash IF/ID contents at this edge (comb)
- fwd_a  out  2  ALU operand A select for instruction now in EX: 00 regfile, 01 from EX/MEM, 10 from MEM/WB (registered)
- fwd_b  out  2  same for operand B (registered)
- stall_count  out  CNT_W  number of load-use bubbles since reset, saturating (registered)

## Operation
- Instruction classes, decoded from id_op_code:
  - 000000 and 010000 (R-type): reads rs1 and rs2; writes ws.
  - 000010 and 010011 (jump): reads nothing; writes nothing; jump = 1.
  - 000100 and 000101 (branch) and 101011 (store): read rs1 and rs2; write nothing.
  - LOAD_OP: reads rs1; writes rs2; load = 1.
  - All other opcodes (I-type ALU): read rs1; write rs2.
- Register 0 is never a hazard. Reads or writes of r0 are treated as "not used".
- State is two slots: EX {v, reg, load} and MEM {v, reg}. All slots are invalid at reset.
- Load-use hazard: id_valid, and a used source equals EX.reg with EX.v && EX.load. When this holds:
  - stall = 1 and bubble = 1 for exactly that cycle.
  - stall_count increments, saturating at all-ones.
- flush = 1 when id_valid && jump && !stall && !freeze.
- Slot update on each edge with freeze = 0:
  - MEM ← EX.
  - EX ← ID's write target, with v = id_valid && writes && !bubble.
- Forwarding is computed in ID and registered into fwd_a/fwd_b on the same edge that moves the instruction into EX. For each used source:
  - Match with EX slot (valid, non-load) → 01.
  - Otherwise match with MEM slot → 10.
  - Otherwise 00.
  - The EX slot has priority over the MEM slot.
  - Unused sources → 00. Bubble cycles load 00 into both.
- The register file is write-through, so a producer in WB while the consumer is in ID needs no action.
- freeze = 1 dominates everything:
  - stall = 1, bubble = 0, flush = 0.
  - Slots, fwd_a, fwd_b and stall_count hold.

## Timing
- Reset (async) clears: EX/MEM slots, fwd_a = fwd_b = 00, stall_count = 0. stall, bubble and flush evaluate to 0 while the slots are invalid.
- stall, bubble and flush are combinational from the ID inputs and the slots, valid in the same cycle.
- fwd_a/fwd_b have 1-cycle latency: they change at the edge the consumer enters EX and are valid throughout its EX cycle.
- Load followed by a dependent instruction:
  - Cycle t: stall/bubble.
  - Cycle t+1: the load is in MEM. The consumer is re-evaluated and gets select 10 in EX at t+2.
- Load followed by an independent instruction, then a dependent one: no stall; select 10.
- ALU producer followed immediately by a consumer: no stall; select 01.
- Simultaneous load-use hazard and jump in ID: impossible, since a jump reads nothing. A jump behind a stalled load cannot reach ID.
- Reset asserted mid-stall or mid-freeze: all state clears immediately. The first cycle after release has no hazards.

## Test plan
- Reset released; R-type add r3 = r1 + r2 with id_valid → stall = bubble = flush = 0; next cycle fwd_a = fwd_b = 00.
- add r3,r1,r2 then sub r4,r3,r5 on consecutive cycles → no stall; fwd_a = 01 and fwd_b = 00 during sub's EX.
- lw r5 (LOAD_OP, rs2 = 5) then add r6,r5,r5 → one cycle stall = bubble = 1, stall_count = 1; add's EX has fwd_a = fwd_b = 10.
- Jump (op 000010) in ID, no hazard → flush = 1 for that cycle only. Repeat the load-use case with freeze = 1 held for 3 cycles → stall = 1, bubble = 0, counters and selects unchanged until freeze drops.
- Writes to r0 followed by reads of r0 → never stall, selects 00. Preload stall_count to all-ones via repeated hazards (CNT_W = 4 build) → stays 4'hF.
- Assert reset asynchronously during a load-use stall → fwd_a/fwd_b/stall_count read 0 before the next edge; stall = 0 after release.
